// File: rtl/ccx_emem_pkg.sv
// Shared types for the core-complex external memory bridge: FSM encoding and the captured request.
// Optional response timeout is enabled by defining CCX_EMEM_TIMEOUT_EN.
package ccx_emem_pkg;

    localparam int AW_DEFAULT = 39;
    localparam int DW_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic                      rtype;
        logic [AW_DEFAULT-1:0]     addr;
        logic                      wen;
        logic [DW_DEFAULT/8-1:0]   strb;
        logic [DW_DEFAULT-1:0]     wdata;
    } req_t;

endpackage

// File: rtl/ccx_emem_timeout.sv
// Response timeout counter for the emem bridge; present only when CCX_EMEM_TIMEOUT_EN is defined.
// Expires on the cycle the count reaches TIMEOUT_CYCLES-1 while enabled.
module ccx_emem_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic g_clk,
    input  logic g_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] r_count;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_en && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ccx_emem_bridge.sv
// Bridges the single-phase emem req/gnt port onto split valid/ready request and response channels.
// One transaction in flight; define CCX_EMEM_TIMEOUT_EN to add a response timeout.
//
// state | meaning
// IDLE  | waiting for emem_req, captures the request
// REQ   | bus_req_valid high until bus_req_ready
// RSP   | bus_rsp_ready high until bus_rsp_valid
// DONE  | one-cycle emem_gnt with captured response
module ccx_emem_bridge
    import ccx_emem_pkg::*;
#(
    parameter int AW             = AW_DEFAULT,
    parameter int DW             = DW_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            emem_req,
    input  logic            emem_rtype,
    input  logic [AW-1:0]   emem_addr,
    input  logic            emem_wen,
    input  logic [DW/8-1:0] emem_strb,
    input  logic [DW-1:0]   emem_wdata,
    output logic            emem_gnt,
    output logic            emem_err,
    output logic [DW-1:0]   emem_rdata,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic            bus_req_rtype,
    output logic [AW-1:0]   bus_req_addr,
    output logic            bus_req_wen,
    output logic [DW/8-1:0] bus_req_strb,
    output logic [DW-1:0]   bus_req_wdata,
    input  logic            bus_rsp_valid,
    output logic            bus_rsp_ready,
    input  logic            bus_rsp_err,
    input  logic [DW-1:0]   bus_rsp_rdata,
    output logic            busy
);

    state_e        r_state;
    req_t          r_req;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic          w_expired;

`ifdef CCX_EMEM_TIMEOUT_EN
    ccx_emem_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .i_clr     (r_state == ST_IDLE),
        .i_en      ((r_state == ST_REQ) || (r_state == ST_RSP)),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state <= ST_IDLE;
            r_req   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (emem_req) begin
                        r_req.rtype <= emem_rtype;
                        r_req.addr  <= emem_addr;
                        r_req.wen   <= emem_wen;
                        r_req.strb  <= emem_wen ? emem_strb : '0;
                        r_req.wdata <= emem_wdata;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A timeout here abandons the request; the counter would not expire again later.
                    if (w_expired) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (bus_req_ready) begin
                        r_state <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (bus_rsp_valid) begin
                        r_rdata <= bus_rsp_rdata;
                        r_err   <= bus_rsp_err;
                        r_state <= ST_DONE;
                    end else if (w_expired) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_req_valid = (r_state == ST_REQ);
    assign bus_rsp_ready = (r_state == ST_RSP);
    assign emem_gnt      = (r_state == ST_DONE);
    assign emem_err      = (r_state == ST_DONE) && r_err;
    assign emem_rdata    = r_rdata;
    assign busy          = (r_state != ST_IDLE);

    assign bus_req_rtype = r_req.rtype;
    assign bus_req_addr  = r_req.addr;
    assign bus_req_wen   = r_req.wen;
    assign bus_req_strb  = r_req.strb;
    assign bus_req_wdata = r_req.wdata;

endmodule

// File: tb/tb_ccx_emem_bridge.sv
// Self-checking bench for ccx_emem_bridge: directed and randomized transactions against a cycle-schedule model.
// Define CCX_EMEM_TIMEOUT_EN (with the RTL) to also exercise the 16-cycle timeout.
module tb_ccx_emem_bridge;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        emem_req;
    logic        emem_rtype;
    logic [38:0] emem_addr;
    logic        emem_wen;
    logic [7:0]  emem_strb;
    logic [63:0] emem_wdata;
    logic        emem_gnt;
    logic        emem_err;
    logic [63:0] emem_rdata;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_rtype;
    logic [38:0] bus_req_addr;
    logic        bus_req_wen;
    logic [7:0]  bus_req_strb;
    logic [63:0] bus_req_wdata;
    logic        bus_rsp_valid;
    logic        bus_rsp_ready;
    logic        bus_rsp_err;
    logic [63:0] bus_rsp_rdata;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] prev_rdata;

    always #5 g_clk = ~g_clk;

    ccx_emem_bridge #(
        .AW             (39),
        .DW             (64),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .g_clk         (g_clk),
        .g_reset       (g_reset),
        .emem_req      (emem_req),
        .emem_rtype    (emem_rtype),
        .emem_addr     (emem_addr),
        .emem_wen      (emem_wen),
        .emem_strb     (emem_strb),
        .emem_wdata    (emem_wdata),
        .emem_gnt      (emem_gnt),
        .emem_err      (emem_err),
        .emem_rdata    (emem_rdata),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_rtype (bus_req_rtype),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wen   (bus_req_wen),
        .bus_req_strb  (bus_req_strb),
        .bus_req_wdata (bus_req_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_ready (bus_rsp_ready),
        .bus_rsp_err   (bus_rsp_err),
        .bus_rsp_rdata (bus_rsp_rdata),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Transaction schedule from the handshake rules: cycle 0 presents the request, REQ spans
    // cycles 1..1+rd, RSP spans 2+rd..2+rd+sd, and the grant lands in cycle 3+rd+sd.
    // Must be entered just after a rising edge with the bridge idle.
    task automatic run_txn(input logic rt, input logic [38:0] a, input logic w,
                           input logic [7:0] s, input logic [63:0] wd, input int rd,
                           input int sd, input logic e, input logic [63:0] rdat,
                           input logic mut);
        int d;
        d = 3 + rd + sd;
        emem_req   = 1'b1;
        emem_rtype = rt;
        emem_addr  = a;
        emem_wen   = w;
        emem_strb  = s;
        emem_wdata = wd;
        for (int k = 0; k <= d; k++) begin
            bus_req_ready = (k == 1 + rd) || ((k == 0 || k > 1 + rd) && $urandom_range(0, 1) == 1);
            if (k == 2 + rd + sd) begin
                bus_rsp_valid = 1'b1;
                bus_rsp_err   = e;
                bus_rsp_rdata = rdat;
            end else begin
                bus_rsp_valid = (k >= 2 + rd && k < 2 + rd + sd) ? 1'b0 : 1'($urandom_range(0, 1));
                bus_rsp_err   = 1'($urandom_range(0, 1));
                bus_rsp_rdata = rnd64();
            end
            if (mut && k >= 1) begin
                emem_req   = 1'($urandom_range(0, 1));
                emem_rtype = ~rt;
                emem_addr  = 39'(rnd64());
                emem_wen   = ~w;
                emem_strb  = 8'($urandom);
                emem_wdata = rnd64();
            end
            @(negedge g_clk);
            chk("req_valid", bus_req_valid, (k >= 1 && k <= 1 + rd));
            if (k >= 1 && k <= 1 + rd) begin
                chk("req_rtype", bus_req_rtype, rt);
                chk("req_addr", bus_req_addr, a);
                chk("req_wen", bus_req_wen, w);
                chk("req_strb", bus_req_strb, w ? s : 8'h00);
                chk("req_wdata", bus_req_wdata, wd);
            end
            chk("rsp_ready", bus_rsp_ready, (k >= 2 + rd && k <= 2 + rd + sd));
            chk("gnt", emem_gnt, (k == d));
            chk("err", emem_err, (k == d) ? e : 1'b0);
            chk("rdata", emem_rdata, (k == d) ? rdat : prev_rdata);
            chk("busy", busy, (k >= 1));
            @(posedge g_clk);
            #1;
        end
        prev_rdata = rdat;
    endtask

    task automatic idle_cycle();
        emem_req = 1'b0;
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        logic [38:0] a0;
        logic [38:0] a1;
        int          rd_r;
        int          sd_r;

        g_reset       = 1'b1;
        emem_req      = 1'b0;
        emem_rtype    = 1'b0;
        emem_addr     = '0;
        emem_wen      = 1'b0;
        emem_strb     = '0;
        emem_wdata    = '0;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rsp_err   = 1'b0;
        bus_rsp_rdata = '0;
        prev_rdata    = '0;

        repeat (2) @(negedge g_clk);
        chk("rst_gnt", emem_gnt, 1'b0);
        chk("rst_err", emem_err, 1'b0);
        chk("rst_rdata", emem_rdata, 64'h0);
        chk("rst_valid", bus_req_valid, 1'b0);
        chk("rst_rsp_ready", bus_rsp_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", bus_req_addr, 39'h0);
        chk("rst_strb", bus_req_strb, 8'h00);
        g_reset = 1'b0;
        @(posedge g_clk);
        #1;

        // Immediate read, write with slow ready, error response.
        run_txn(1'b0, 39'h10_0000_40, 1'b0, 8'hFF, 64'hAAAA_5555_AAAA_5555, 0, 0, 1'b0,
                64'hDEAD_BEEF_0123_4567, 1'b0);
        idle_cycle();
        run_txn(1'b1, 39'h00_2000_08, 1'b1, 8'h0F, 64'h1122_3344_5566_7788, 5, 2, 1'b0,
                64'h0BAD_F00D_CAFE_0001, 1'b0);
        idle_cycle();
        run_txn(1'b0, 39'h7F_FFFF_FFF8, 1'b0, 8'h00, 64'h0, 1, 1, 1'b1,
                64'h5A5A_5A5A_A5A5_A5A5, 1'b0);
        idle_cycle();

        // Reset while in RSP abandons the transaction.
        emem_req      = 1'b1;
        emem_rtype    = 1'b1;
        emem_addr     = 39'h12_3456_7890;
        emem_wen      = 1'b0;
        bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b0;
        repeat (2) @(posedge g_clk);
        #1;
        emem_req = 1'b0;
        chk("pre_rst_rsp_ready", bus_rsp_ready, 1'b1);
        g_reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rsp_ready", bus_rsp_ready, 1'b0);
        chk("midrst_valid", bus_req_valid, 1'b0);
        chk("midrst_gnt", emem_gnt, 1'b0);
        @(negedge g_clk);
        g_reset       = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 64'hFFFF_0000_FFFF_0000;
        prev_rdata    = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge g_clk);
            chk("postrst_gnt", emem_gnt, 1'b0);
            chk("postrst_busy", busy, 1'b0);
            chk("postrst_rdata", emem_rdata, prev_rdata);
        end
        @(posedge g_clk);
        #1;
        run_txn(1'b1, 39'h00_0000_1000, 1'b1, 8'hA5, 64'h0123_4567_89AB_CDEF, 2, 0, 1'b0,
                64'h1357_9BDF_2468_ACE0, 1'b0);
        idle_cycle();

        // Back-to-back with req held; second request presented right after the grant.
        run_txn(1'b0, 39'h01_0000_0100, 1'b0, 8'h00, 64'h0, 0, 0, 1'b0,
                64'h1111_1111_1111_1111, 1'b0);
        run_txn(1'b0, 39'h02_0000_0200, 1'b0, 8'h00, 64'h0, 0, 0, 1'b0,
                64'h2222_2222_2222_2222, 1'b0);
        idle_cycle();

        // Randomized traffic, including mid-transaction req drop and field changes.
        for (int t = 0; t < 24; t++) begin
            a0   = 39'(rnd64());
            rd_r = $urandom_range(0, 4);
            sd_r = $urandom_range(0, 4);
            run_txn(1'($urandom_range(0, 1)), a0, 1'($urandom_range(0, 1)), 8'($urandom),
                    rnd64(), rd_r, sd_r, 1'($urandom_range(0, 3) == 0), rnd64(),
                    1'($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

`ifdef CCX_EMEM_TIMEOUT_EN
        // No response: grant with error and zero data 16 cycles after entering REQ (cycle 1).
        a1         = 39'h33_0000_0040;
        emem_req   = 1'b1;
        emem_rtype = 1'b0;
        emem_addr  = a1;
        emem_wen   = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            bus_req_ready = (k == 1);
            bus_rsp_valid = 1'b0;
            if (k >= 1) emem_req = 1'b0;
            @(negedge g_clk);
            chk("to_gnt", emem_gnt, (k == 17));
            chk("to_err", emem_err, (k == 17));
            chk("to_busy", busy, (k >= 1));
            chk("to_rdata", emem_rdata, (k == 17) ? 64'h0 : prev_rdata);
            @(posedge g_clk);
            #1;
        end
        prev_rdata = '0;
        @(negedge g_clk);
        chk("to_after_busy", busy, 1'b0);
        @(posedge g_clk);
        #1;
`else
        a1 = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
